// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// states, opcode/funct values and datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_R_EXEC   = 4'd2,
    ST_R_WB     = 4'd3,
    ST_I_EXEC   = 4'd4,
    ST_I_WB     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_UP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: opcode/funct to alu_ctrl plus a
// legality flag that DECODE uses to trap unsupported encodings.
module mc_alu_dec import mc_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       valid
);

  logic rt;
  assign rt = (opcode == OP_RTYPE);

  // one-hot style decode of every supported instruction
  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b0;
    unique case (1'b1)
      rt && (funct == FN_ADD): begin alu_ctrl = ALU_ADD; valid = 1'b1; end
      rt && (funct == FN_SUB): begin alu_ctrl = ALU_SUB; valid = 1'b1; end
      rt && (funct == FN_AND): begin alu_ctrl = ALU_AND; valid = 1'b1; end
      rt && (funct == FN_OR):  begin alu_ctrl = ALU_OR;  valid = 1'b1; end
      rt && (funct == FN_SLT): begin alu_ctrl = ALU_SLT; valid = 1'b1; end
      (opcode == OP_ORI):      begin alu_ctrl = ALU_OR;  valid = 1'b1; end
      (opcode == OP_LUI):      begin alu_ctrl = ALU_PASSB; valid = 1'b1; end
      (opcode == OP_BEQ):      begin alu_ctrl = ALU_SUB; valid = 1'b1; end
      (opcode == OP_ADDI),
      (opcode == OP_LW),
      (opcode == OP_SW),
      (opcode == OP_J):        begin alu_ctrl = ALU_ADD; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM with memory handshake watchdog.
// Define PERF_CNT_EN to add the 32-bit retired-instruction counter.
module mc_ctrl import mc_pkg::*; #(
  parameter int ALUCTRL_W  = 3,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem2reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [1:0]           ext_op,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 illegal,
  output logic                 mem_timeout,
  output logic [3:0]           state_dbg
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]          retired
`endif
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(WAIT_LIMIT);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             wait_st, tmo;
  logic [2:0]       dec_ctrl, aluc;
  logic             dec_valid;
  logic [1:0]       ext_sel;
  logic             pcw_c, pcwc_c, mwr_c, irw_c, rwr_c;

  // zero gates the PC load in the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  mc_alu_dec u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .valid    (dec_valid)
  );

  assign ext_sel = (opcode == OP_ORI) ? EXT_ZERO :
                   (opcode == OP_LUI) ? EXT_UP : EXT_SIGN;

  assign wait_st = (state == ST_FETCH) || (state == ST_MEM_RD) ||
                   (state == ST_MEM_WR);
  assign tmo     = wait_st && !mem_ready && (cnt == LIM);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= nxt;
  end

  // watchdog: counts stalled cycles, restarts on any exit or expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (!wait_st || tmo || nxt != state) cnt <= '0;
    else if (!mem_ready)                       cnt <= cnt + CNT_W'(1);
  end

  // next state and Moore strobes
  always_comb begin
    nxt       = state;
    pcw_c     = 1'b0;
    pcwc_c    = 1'b0;
    mwr_c     = 1'b0;
    irw_c     = 1'b0;
    rwr_c     = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem2reg   = 1'b0;
    reg_dst   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    pc_source = PCS_ALU;
    ext_op    = EXT_SIGN;
    aluc      = ALU_ADD;
    illegal   = 1'b0;
    unique case (state)
      ST_FETCH: begin
        mem_read  = !tmo;
        alu_src_b = SRCB_4;
        if (mem_ready) begin
          irw_c = 1'b1;
          pcw_c = 1'b1;
          nxt   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM2;
        if (!dec_valid) begin
          illegal = 1'b1;
          nxt     = ST_FETCH;
        end else begin
          unique case (opcode)
            OP_RTYPE:               nxt = ST_R_EXEC;
            OP_LW, OP_SW:           nxt = ST_MEM_ADDR;
            OP_BEQ:                 nxt = ST_BRANCH;
            OP_J:                   nxt = ST_JUMP;
            OP_ADDI, OP_ORI, OP_LUI: nxt = ST_I_EXEC;
            default:                nxt = ST_FETCH;
          endcase
        end
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        aluc      = dec_ctrl;
        nxt       = ST_R_WB;
      end
      ST_R_WB: begin
        reg_dst = 1'b1;
        rwr_c   = 1'b1;
        nxt     = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = ext_sel;
        aluc      = dec_ctrl;
        nxt       = ST_I_WB;
      end
      ST_I_WB: begin
        rwr_c  = 1'b1;
        ext_op = ext_sel;
        aluc   = dec_ctrl;
        nxt    = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = !tmo;
        if (mem_ready) nxt = ST_MEM_WB;
        else if (tmo)  nxt = ST_FETCH;
      end
      ST_MEM_WB: begin
        mem2reg = 1'b1;
        rwr_c   = 1'b1;
        nxt     = ST_FETCH;
      end
      ST_MEM_WR: begin
        iord  = 1'b1;
        mwr_c = !tmo;
        if (mem_ready || tmo) nxt = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        aluc      = ALU_SUB;
        pc_source = PCS_OUT;
        pcwc_c    = 1'b1;
        nxt       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_source = PCS_JMP;
        pcw_c     = 1'b1;
        nxt       = ST_FETCH;
      end
      default: nxt = ST_FETCH;
    endcase
  end

  // architectural writes are held off while reset is low
  assign pc_write      = pcw_c  & rst_n;
  assign pc_write_cond = pcwc_c & rst_n;
  assign ir_write      = irw_c  & rst_n;
  assign reg_write     = rwr_c  & rst_n;
  assign mem_write     = mwr_c  & rst_n;

  assign alu_ctrl    = ALUCTRL_W'(aluc);
  assign mem_timeout = tmo;
  assign state_dbg   = state;

`ifdef PERF_CNT_EN
  logic ret_ev;
  assign ret_ev = (state == ST_R_WB) || (state == ST_I_WB) ||
                  (state == ST_MEM_WB) || (state == ST_BRANCH) ||
                  (state == ST_JUMP) ||
                  ((state == ST_MEM_WR) && mem_ready);

  // count completed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (ret_ev) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with a queue of expected
// per-cycle state/strobe snapshots.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem2reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, ext_op;
  logic [2:0] alu_ctrl;
  logic       illegal, mem_timeout;
  logic [3:0] state_dbg;
`ifdef PERF_CNT_EN
  logic [31:0] retired;
  int unsigned exp_ret = 0;
`endif

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, pcsrc, ext;
    logic [2:0] aluc;
    logic ill, tmo;
  } obs_t;

  typedef struct {
    string  tag;
    state_t st;
    obs_t   v;
    obs_t   c;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem2reg(mem2reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .ext_op(ext_op),
    .alu_ctrl(alu_ctrl), .illegal(illegal),
    .mem_timeout(mem_timeout), .state_dbg(state_dbg)
`ifdef PERF_CNT_EN
    , .retired(retired)
`endif
  );

  function automatic logic legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011, 6'b101011, 6'b000100, 6'b000010,
      6'b001000, 6'b001101, 6'b001111: return 1'b1;
      6'b000000: return fn inside {6'b100000, 6'b100010, 6'b100100,
                                   6'b100101, 6'b101010};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] rfn(logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      6'b101010: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  // expected strobes for a state; c marks the fields that matter
  function automatic exp_t mk(string tag, state_t st, logic rdy,
                              logic tmo, logic rst);
    exp_t e;
    obs_t v, c;
    v = '0;
    c = '0;
    c.pcw = 1; c.pcwc = 1; c.mwr = 1; c.irw = 1; c.rwr = 1;
    c.ill = 1; c.tmo = 1;
    case (st)
      ST_FETCH: begin
        c.mrd = !tmo; v.mrd = 1'b1;
        c.iord = 1; c.srca = 1;
        c.srcb = '1; v.srcb = 2'b01;
        c.aluc = '1; c.pcsrc = '1;
        v.irw = rdy & !rst; v.pcw = rdy & !rst;
        v.tmo = tmo;
      end
      ST_DECODE: begin
        c.srca = 1; c.srcb = '1; v.srcb = 2'b11; c.aluc = '1;
        v.ill = !legal(opcode, funct);
      end
      ST_R_EXEC: begin
        c.srca = 1; v.srca = 1; c.srcb = '1;
        c.aluc = '1; v.aluc = rfn(funct);
      end
      ST_R_WB: begin
        c.rdst = 1; v.rdst = 1; v.rwr = 1; c.m2r = 1;
      end
      ST_I_EXEC, ST_I_WB: begin
        c.aluc = '1; c.ext = '1;
        case (opcode)
          6'b001101: begin v.aluc = 3'b011; v.ext = 2'b01; end
          6'b001111: begin v.aluc = 3'b101; v.ext = 2'b10; end
          default:   begin v.aluc = 3'b000; v.ext = 2'b00; end
        endcase
        if (st == ST_I_EXEC) begin
          c.srca = 1; v.srca = 1; c.srcb = '1; v.srcb = 2'b10;
        end else begin
          c.rdst = 1; v.rwr = 1; c.m2r = 1;
        end
      end
      ST_MEM_ADDR: begin
        c.srca = 1; v.srca = 1; c.srcb = '1; v.srcb = 2'b10;
        c.ext = '1; c.aluc = '1;
      end
      ST_MEM_RD: begin
        c.iord = 1; v.iord = 1; c.mrd = !tmo; v.mrd = 1; v.tmo = tmo;
      end
      ST_MEM_WB: begin
        c.rdst = 1; c.m2r = 1; v.m2r = 1; v.rwr = 1;
      end
      ST_MEM_WR: begin
        c.iord = 1; v.iord = 1; v.mwr = !tmo & !rst; v.tmo = tmo;
      end
      ST_BRANCH: begin
        c.srca = 1; v.srca = 1; c.srcb = '1;
        c.aluc = '1; v.aluc = 3'b001;
        c.pcsrc = '1; v.pcsrc = 2'b01; v.pcwc = 1;
      end
      ST_JUMP: begin
        c.pcsrc = '1; v.pcsrc = 2'b10; v.pcw = 1;
      end
      default: ;
    endcase
    e.tag = tag; e.st = st; e.v = v; e.c = c;
    return e;
  endfunction

  task automatic chk();
    exp_t e;
    obs_t o;
    e = q.pop_front();
    o = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
         mem2reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
         ext_op, alu_ctrl, illegal, mem_timeout};
    n_chk++;
    assert (state_dbg === e.st) else begin
      n_fail++;
      $error("FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
    end
    n_chk++;
    assert ((o & e.c) === (e.v & e.c)) else begin
      n_fail++;
      $error("FAIL %s strobes: got %h want %h mask %h",
             e.tag, o & e.c, e.v & e.c, e.c);
    end
  endtask

  // one cycle: drive at negedge, check 1ns later, advance
  task automatic step(string tag, state_t st, logic rdy, logic tmo);
    mem_ready = rdy;
    q.push_back(mk(tag, st, rdy, tmo, 1'b0));
    #1;
    chk();
`ifdef PERF_CNT_EN
    if (st inside {ST_R_WB, ST_I_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP} ||
        (st == ST_MEM_WR && rdy))
      exp_ret++;
`endif
    @(negedge clk);
  endtask

  task automatic chk_ret(string tag);
`ifdef PERF_CNT_EN
    n_chk++;
    assert (retired === exp_ret) else begin
      n_fail++;
      $error("FAIL %s retired: got %0d want %0d", tag, retired, exp_ret);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #12;
    q.push_back(mk("reset", ST_FETCH, 1'b1, 1'b0, 1'b1));
    #1;
    chk();
    chk_ret("reset");
    @(negedge clk);
    rst_n = 1'b1;

    opcode = 6'h00; funct = 6'h20;
    step("add_f", ST_FETCH, 1, 0);
    step("add_d", ST_DECODE, 1, 0);
    step("add_x", ST_R_EXEC, 1, 0);
    step("add_wb", ST_R_WB, 1, 0);

    funct = 6'h2a;
    step("slt_f", ST_FETCH, 1, 0);
    step("slt_d", ST_DECODE, 1, 0);
    step("slt_x", ST_R_EXEC, 1, 0);
    step("slt_wb", ST_R_WB, 1, 0);

    opcode = 6'h23;
    step("lw_f", ST_FETCH, 1, 0);
    step("lw_d", ST_DECODE, 1, 0);
    step("lw_a", ST_MEM_ADDR, 0, 0);
    for (int i = 0; i < 3; i++) step("lw_wait", ST_MEM_RD, 0, 0);
    step("lw_rd", ST_MEM_RD, 1, 0);
    step("lw_wb", ST_MEM_WB, 1, 0);

    opcode = 6'h2b;
    step("sw_f", ST_FETCH, 1, 0);
    step("sw_d", ST_DECODE, 1, 0);
    step("sw_a", ST_MEM_ADDR, 0, 0);
    step("sw_wait", ST_MEM_WR, 0, 0);
    step("sw_wr", ST_MEM_WR, 1, 0);

    opcode = 6'h04; zero = 1'b1;
    step("beq1_f", ST_FETCH, 1, 0);
    step("beq1_d", ST_DECODE, 1, 0);
    step("beq1_b", ST_BRANCH, 1, 0);
    zero = 1'b0;
    step("beq0_f", ST_FETCH, 1, 0);
    step("beq0_d", ST_DECODE, 1, 0);
    step("beq0_b", ST_BRANCH, 1, 0);

    opcode = 6'h02;
    step("j_f", ST_FETCH, 1, 0);
    step("j_d", ST_DECODE, 1, 0);
    step("j_j", ST_JUMP, 1, 0);

    opcode = 6'h0d;
    step("ori_f", ST_FETCH, 1, 0);
    step("ori_d", ST_DECODE, 1, 0);
    step("ori_x", ST_I_EXEC, 1, 0);
    step("ori_wb", ST_I_WB, 1, 0);

    opcode = 6'h0f;
    step("lui_f", ST_FETCH, 1, 0);
    step("lui_d", ST_DECODE, 1, 0);
    step("lui_x", ST_I_EXEC, 1, 0);
    step("lui_wb", ST_I_WB, 1, 0);

    opcode = 6'h08;
    step("addi_f", ST_FETCH, 1, 0);
    step("addi_d", ST_DECODE, 1, 0);
    step("addi_x", ST_I_EXEC, 1, 0);
    step("addi_wb", ST_I_WB, 1, 0);

    opcode = 6'h00; funct = 6'h21;
    step("ilfn_f", ST_FETCH, 1, 0);
    step("ilfn_d", ST_DECODE, 1, 0);

    opcode = 6'h3f;
    step("ilop_f", ST_FETCH, 1, 0);
    step("ilop_d", ST_DECODE, 1, 0);

    opcode = 6'h02;
    for (int i = 0; i < 15; i++) step("fwait", ST_FETCH, 0, 0);
    step("ftmo", ST_FETCH, 0, 1);
    step("frefetch", ST_FETCH, 1, 0);
    step("frefetch_d", ST_DECODE, 1, 0);
    step("frefetch_j", ST_JUMP, 1, 0);

    opcode = 6'h23;
    step("lwl_f", ST_FETCH, 1, 0);
    step("lwl_d", ST_DECODE, 1, 0);
    step("lwl_a", ST_MEM_ADDR, 0, 0);
    for (int i = 0; i < 15; i++) step("lwl_wait", ST_MEM_RD, 0, 0);
    step("lwl_rdy_wins", ST_MEM_RD, 1, 0);
    step("lwl_wb", ST_MEM_WB, 1, 0);
    chk_ret("pre_rst");

    opcode = 6'h2b;
    step("swr_f", ST_FETCH, 1, 0);
    step("swr_d", ST_DECODE, 1, 0);
    step("swr_a", ST_MEM_ADDR, 0, 0);
    mem_ready = 1'b0;
    q.push_back(mk("swr_wr", ST_MEM_WR, 1'b0, 1'b0, 1'b0));
    #1;
    chk();
    #1;
    rst_n = 1'b0;
`ifdef PERF_CNT_EN
    exp_ret = 0;
`endif
    q.push_back(mk("swr_rst", ST_FETCH, 1'b0, 1'b0, 1'b1));
    #1;
    chk();
    chk_ret("swr_rst");
    @(negedge clk);
    rst_n = 1'b1;

    opcode = 6'h02;
    step("post_f", ST_FETCH, 1, 0);
    step("post_d", ST_DECODE, 1, 0);
    step("post_j", ST_JUMP, 1, 0);
    #1;
    chk_ret("final");

    n_chk++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain: got %0d left want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
